multicycle_control_unit: RTL and testbench

//  Multi-cycle successor to the single-cycle RV32I decoder. It is an FSM that sequences each

---
 rtl/multicycle_control_unit_if.sv | 36 +++
 rtl/multicycle_control_unit.sv | 189 ++++++++++++++++++
 tb/tb_multicycle_control_unit.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/multicycle_control_unit_if.sv
// Control bundle between the instruction register, data memory and the
// multi-cycle control unit.
interface multicycle_control_unit_if #(
    parameter int ALU_CTRL_W = 4,
    parameter int WDSEL_W    = 3
);
    logic [31:0]           instrCode;
    logic                  dataReady;
    logic                  instrLatch;
    logic                  pcEn;
    logic                  regFileWe;
    logic [ALU_CTRL_W-1:0] aluControl;
    logic                  aluSrcMuxSel;
    logic                  dataReq;
    logic                  dataWe;
    logic [WDSEL_W-1:0]    rfWdSrcSel;
    logic                  branch;
    logic                  jal;
    logic                  jalr;
    logic                  illegalInstr;
    logic                  busErr;

    modport master (
        input  instrCode, dataReady,
        output instrLatch, pcEn, regFileWe, aluControl, aluSrcMuxSel,
        output dataReq, dataWe, rfWdSrcSel, branch, jal, jalr,
        output illegalInstr, busErr
    );

    modport slave (
        output instrCode, dataReady,
        input  instrLatch, pcEn, regFileWe, aluControl, aluSrcMuxSel,
        input  dataReq, dataWe, rfWdSrcSel, branch, jal, jalr,
        input  illegalInstr, busErr
    );
endinterface

// File: rtl/multicycle_control_unit.sv
// RV32I multi-cycle control FSM: sequences FETCH/DECODE/EXECUTE/MEM/WB and
// drives datapath strobes; waits on a variable-latency data memory.
module multicycle_control_unit #(
    parameter int ALU_CTRL_W  = 4,
    parameter int WDSEL_W     = 3,
    parameter int MEM_TIMEOUT = 16
) (
    input  logic                      clk,
    input  logic                      reset,
    multicycle_control_unit_if.master bus
);
    localparam int CNT_W = $clog2(MEM_TIMEOUT);

    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;
    localparam logic [6:0] OP_S     = 7'b0100011;
    localparam logic [6:0] OP_L     = 7'b0000011;
    localparam logic [6:0] OP_B     = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;

    typedef enum logic [3:0] {
        FETCH, DECODE, EXE_WB, S_ADDR, S_MEM,
        L_ADDR, L_MEM, L_WB, BR, JUMP, HALT
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic [31:0]      r_instr;
    logic [CNT_W-1:0] r_cnt;
    logic             r_illegal;
    logic             r_buserr;

    logic [6:0] w_op;
    logic [2:0] w_f3;
    logic       w_f7b5;
    logic       w_in_mem;
    logic       w_tmo;
    logic       w_unused;

    logic                  w_instrLatch;
    logic                  w_pcEn;
    logic                  w_regFileWe;
    logic [ALU_CTRL_W-1:0] w_aluControl;
    logic                  w_aluSrc;
    logic                  w_dataReq;
    logic                  w_dataWe;
    logic [WDSEL_W-1:0]    w_wdSel;
    logic                  w_branch;
    logic                  w_jal;
    logic                  w_jalr;
    logic                  w_set_ill;
    logic                  w_set_be;

    assign w_op     = r_instr[6:0];
    assign w_f3     = r_instr[14:12];
    assign w_f7b5   = r_instr[30];
    assign w_unused = ^{r_instr[31], r_instr[29:15], r_instr[11:7]};
    assign w_in_mem = (r_state == S_MEM) || (r_state == L_MEM);
    assign w_tmo    = (r_cnt == CNT_W'(MEM_TIMEOUT - 1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= FETCH;
            r_instr   <= 32'h0;
            r_cnt     <= '0;
            r_illegal <= 1'b0;
            r_buserr  <= 1'b0;
        end else begin
            r_state <= w_next;
            if (r_state == FETCH)
                r_instr <= bus.instrCode;
            // Counter is zero whenever a memory wait state is entered
            r_cnt <= w_in_mem ? r_cnt + 1'b1 : '0;
            if (w_set_ill)
                r_illegal <= 1'b1;
            if (w_set_be)
                r_buserr <= 1'b1;
        end
    end

    always_comb begin
        w_next       = r_state;
        w_instrLatch = 1'b0;
        w_pcEn       = 1'b0;
        w_regFileWe  = 1'b0;
        w_aluControl = '0;
        w_aluSrc     = 1'b0;
        w_dataReq    = 1'b0;
        w_dataWe     = 1'b0;
        w_wdSel      = '0;
        w_branch     = 1'b0;
        w_jal        = 1'b0;
        w_jalr       = 1'b0;
        w_set_ill    = 1'b0;
        w_set_be     = 1'b0;
        unique case (r_state)
            FETCH: begin
                w_instrLatch = 1'b1;
                w_next       = DECODE;
            end
            DECODE: begin
                unique case (w_op)
                    OP_R, OP_I, OP_LUI, OP_AUIPC: w_next = EXE_WB;
                    OP_S:                         w_next = S_ADDR;
                    OP_L:                         w_next = L_ADDR;
                    OP_B:                         w_next = BR;
                    OP_JAL, OP_JALR:              w_next = JUMP;
                    default: begin
                        w_next    = HALT;
                        w_set_ill = 1'b1;
                    end
                endcase
            end
            EXE_WB: begin
                w_regFileWe = 1'b1;
                w_pcEn      = 1'b1;
                w_next      = FETCH;
                unique case (w_op)
                    OP_R: w_aluControl = ALU_CTRL_W'({w_f7b5, w_f3});
                    OP_I: begin
                        w_aluControl = ALU_CTRL_W'({(w_f3 == 3'b101) & w_f7b5, w_f3});
                        w_aluSrc     = 1'b1;
                    end
                    OP_LUI:   w_wdSel = WDSEL_W'(2);
                    OP_AUIPC: w_wdSel = WDSEL_W'(3);
                    default:  w_wdSel = '0;
                endcase
            end
            S_ADDR, L_ADDR: begin
                w_aluSrc = 1'b1;
                w_next   = (r_state == S_ADDR) ? S_MEM : L_MEM;
            end
            S_MEM, L_MEM: begin
                w_aluSrc  = 1'b1;
                w_dataReq = 1'b1;
                w_dataWe  = (r_state == S_MEM);
                // A ready arriving on the last allowed cycle still completes
                if (bus.dataReady) begin
                    w_pcEn = (r_state == S_MEM);
                    w_next = (r_state == S_MEM) ? FETCH : L_WB;
                end else if (w_tmo) begin
                    w_set_be = 1'b1;
                    w_next   = HALT;
                end
            end
            L_WB: begin
                w_regFileWe = 1'b1;
                w_wdSel     = WDSEL_W'(1);
                w_pcEn      = 1'b1;
                w_next      = FETCH;
            end
            BR: begin
                w_aluControl = ALU_CTRL_W'({1'b0, w_f3});
                w_branch     = 1'b1;
                w_pcEn       = 1'b1;
                w_next       = FETCH;
            end
            JUMP: begin
                w_jal       = (w_op == OP_JAL);
                w_jalr      = (w_op == OP_JALR);
                w_aluSrc    = (w_op == OP_JALR);
                w_regFileWe = 1'b1;
                w_wdSel     = WDSEL_W'(4);
                w_pcEn      = 1'b1;
                w_next      = FETCH;
            end
            HALT:    w_next = HALT;
            default: w_next = HALT;
        endcase
    end

    // Strobes are forced low while reset is held
    assign bus.instrLatch   = reset & w_instrLatch;
    assign bus.pcEn         = reset & w_pcEn;
    assign bus.regFileWe    = reset & w_regFileWe;
    assign bus.aluControl   = reset ? w_aluControl : '0;
    assign bus.aluSrcMuxSel = reset & w_aluSrc;
    assign bus.dataReq      = reset & w_dataReq;
    assign bus.dataWe       = reset & w_dataWe;
    assign bus.rfWdSrcSel   = reset ? w_wdSel : '0;
    assign bus.branch       = reset & w_branch;
    assign bus.jal          = reset & w_jal;
    assign bus.jalr         = reset & w_jalr;
    assign bus.illegalInstr = r_illegal;
    assign bus.busErr       = r_buserr;
endmodule

// File: tb/tb_multicycle_control_unit.sv
// Directed bench for multicycle_control_unit: vector table for single-cycle
// execute instructions plus memory, timeout, illegal and reset sequences.
module tb_multicycle_control_unit;
    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    multicycle_control_unit_if #(.ALU_CTRL_W(4), .WDSEL_W(3)) bus ();

    multicycle_control_unit #(
        .ALU_CTRL_W(4), .WDSEL_W(3), .MEM_TIMEOUT(16)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    typedef struct {
        logic [31:0] instr;
        logic [17:0] exp;
    } vec_t;

    vec_t vt[11];
    int checks = 0;
    int errors = 0;

    function automatic logic [17:0] mk(
        input logic il, pc, we, input logic [3:0] alu,
        input logic src, rq, dwe, input logic [2:0] wd,
        input logic br, jl, jr, ill, be);
        return {il, pc, we, alu, src, rq, dwe, wd, br, jl, jr, ill, be};
    endfunction

    function automatic logic [17:0] obs();
        return {bus.instrLatch, bus.pcEn, bus.regFileWe, bus.aluControl,
                bus.aluSrcMuxSel, bus.dataReq, bus.dataWe, bus.rfWdSrcSel,
                bus.branch, bus.jal, bus.jalr, bus.illegalInstr, bus.busErr};
    endfunction

    task automatic chk(input string nm, input logic [17:0] exp);
        logic [17:0] got;
        got = obs();
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %05h expected %05h", nm, got, exp);
        end
    endtask

    task automatic tick(input logic rdy);
        @(negedge clk);
        bus.dataReady = rdy;
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0;
        bus.dataReady = 1'b0;
        bus.instrCode = 32'h0;
        #1;
        chk("reset", 18'h0);
        reset = 1'b1;
        #1;
    endtask

    logic [17:0] FETCH_E, ZERO_E, SADDR_E, SMEM_E, LMEM_E, HALT_BE, HALT_IL;

    initial begin
        bus.instrCode = 32'h0;
        bus.dataReady = 1'b0;
        FETCH_E = mk(1,0,0,4'h0,0,0,0,3'd0,0,0,0,0,0);
        ZERO_E  = 18'h0;
        SADDR_E = mk(0,0,0,4'h0,1,0,0,3'd0,0,0,0,0,0);
        SMEM_E  = mk(0,0,0,4'h0,1,1,1,3'd0,0,0,0,0,0);
        LMEM_E  = mk(0,0,0,4'h0,1,1,0,3'd0,0,0,0,0,0);
        HALT_BE = mk(0,0,0,4'h0,0,0,0,3'd0,0,0,0,0,1);
        HALT_IL = mk(0,0,0,4'h0,0,0,0,3'd0,0,0,0,1,0);

        vt[0]  = '{32'h002081B3, mk(0,1,1,4'h0,0,0,0,3'd0,0,0,0,0,0)};
        vt[1]  = '{32'h402081B3, mk(0,1,1,4'h8,0,0,0,3'd0,0,0,0,0,0)};
        vt[2]  = '{32'h4020D193, mk(0,1,1,4'hD,1,0,0,3'd0,0,0,0,0,0)};
        vt[3]  = '{32'h40000093, mk(0,1,1,4'h0,1,0,0,3'd0,0,0,0,0,0)};
        vt[4]  = '{32'h0020A1B3, mk(0,1,1,4'h2,0,0,0,3'd0,0,0,0,0,0)};
        vt[5]  = '{32'h123450B7, mk(0,1,1,4'h0,0,0,0,3'd2,0,0,0,0,0)};
        vt[6]  = '{32'h00001097, mk(0,1,1,4'h0,0,0,0,3'd3,0,0,0,0,0)};
        vt[7]  = '{32'h00208463, mk(0,1,0,4'h0,0,0,0,3'd0,1,0,0,0,0)};
        vt[8]  = '{32'h00209463, mk(0,1,0,4'h1,0,0,0,3'd0,1,0,0,0,0)};
        vt[9]  = '{32'h008000EF, mk(0,1,1,4'h0,0,0,0,3'd4,0,1,0,0,0)};
        vt[10] = '{32'h000080E7, mk(0,1,1,4'h0,1,0,0,3'd4,0,0,1,0,0)};

        do_reset();

        for (int i = 0; i < 11; i++) begin
            bus.instrCode = vt[i].instr;
            chk($sformatf("v%0d_fetch", i), FETCH_E);
            tick(0);
            chk($sformatf("v%0d_decode", i), ZERO_E);
            tick(0);
            chk($sformatf("v%0d_exec", i), vt[i].exp);
            tick(0);
        end

        // store with dataReady high early: ignored until S_MEM
        bus.instrCode = 32'h0030A023;
        chk("sw_fast_fetch", FETCH_E);
        tick(1); chk("sw_fast_decode", ZERO_E);
        tick(1); chk("sw_fast_addr", SADDR_E);
        tick(1); chk("sw_fast_mem", SMEM_E | mk(0,1,0,4'h0,0,0,0,3'd0,0,0,0,0,0));
        tick(0); chk("sw_fast_next", FETCH_E);

        // load with two wait cycles
        bus.instrCode = 32'h0000A183;
        tick(0); chk("lw_decode", ZERO_E);
        tick(0); chk("lw_addr", SADDR_E);
        tick(0); chk("lw_mem0", LMEM_E);
        tick(0); chk("lw_mem1", LMEM_E);
        tick(1); chk("lw_mem2", LMEM_E);
        tick(0); chk("lw_wb", mk(0,1,1,4'h0,0,0,0,3'd1,0,0,0,0,0));
        tick(0); chk("lw_next", FETCH_E);

        // store whose ready arrives on the last allowed wait cycle
        bus.instrCode = 32'h0030A023;
        tick(0); chk("sw_edge_decode", ZERO_E);
        tick(0); chk("sw_edge_addr", SADDR_E);
        for (int k = 0; k < 16; k++) begin
            tick(k == 15);
            chk($sformatf("sw_edge_mem%0d", k),
                SMEM_E | mk(0,(k == 15),0,4'h0,0,0,0,3'd0,0,0,0,0,0));
        end
        tick(0); chk("sw_edge_next", FETCH_E);

        // reset asserted while a load waits in L_MEM
        bus.instrCode = 32'h0000A183;
        tick(0); chk("rst_decode", ZERO_E);
        tick(0); chk("rst_addr", SADDR_E);
        tick(0); chk("rst_lmem", LMEM_E);
        reset = 1'b0;
        #1; chk("rst_mid", ZERO_E);
        reset = 1'b1;
        #1; chk("rst_refetch", FETCH_E);

        // store timeout
        bus.instrCode = 32'h0030A023;
        tick(0); chk("tmo_decode", ZERO_E);
        tick(0); chk("tmo_addr", SADDR_E);
        for (int k = 0; k < 16; k++) begin
            tick(0);
            chk($sformatf("tmo_mem%0d", k), SMEM_E);
        end
        tick(0); chk("tmo_halt", HALT_BE);
        for (int k = 0; k < 3; k++) begin
            tick(1);
            chk($sformatf("tmo_hold%0d", k), HALT_BE);
        end

        // illegal opcode
        do_reset();
        bus.instrCode = 32'h0000007F;
        chk("ill_fetch", FETCH_E);
        tick(0); chk("ill_decode", ZERO_E);
        for (int k = 0; k < 4; k++) begin
            tick(k[0]);
            chk($sformatf("ill_halt%0d", k), HALT_IL);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
